// File: rtl/sqrt_f32_issue_if.sv
// sqrt_f32_issue_if: operand stream, core link and result stream of the sqrt issue sequencer
interface sqrt_f32_issue_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             core_start;
  logic [WIDTH-1:0] core_a;
  logic             core_rdy;
  logic [WIDTH-1:0] core_sqrt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_flags;
  logic             busy;
  modport master (
    output in_valid, in_data, out_ready, core_rdy, core_sqrt,
    input  in_ready, core_start, core_a, out_valid, out_data, out_flags, busy
  );
  modport slave (
    input  in_valid, in_data, out_ready, core_rdy, core_sqrt,
    output in_ready, core_start, core_a, out_valid, out_data, out_flags, busy
  );
endinterface

// File: rtl/sqrt_f32_issue.sv
// sqrt_f32_issue: issues f32 operands one at a time to a sqrt core, buffers results, bypasses negatives, times out stalls
module sqrt_f32_issue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 40
) (
  input logic clk,
  input logic rst,
  sqrt_f32_issue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [AW-1:0] wp, rp;
  logic [WW-1:0] wd;
  logic [WIDTH+1:0] mem [DEPTH];
  logic accept, neg, rdy_done, to_done, push, pop;
  logic [WIDTH+1:0] push_entry;
  // negative non-zero, non-NaN operands never reach the core
  assign neg = bus.in_data[WIDTH-1] && |bus.in_data[WIDTH-2:0]
            && !(&bus.in_data[30:23] && |bus.in_data[22:0]);
  assign bus.in_ready = rst && state == IDLE && count < CW'(DEPTH);
  assign accept = bus.in_valid && bus.in_ready;
  assign rdy_done = state == WAIT && bus.core_rdy;
  assign to_done = state == WAIT && !bus.core_rdy && wd == WW'(TIMEOUT - 1);
  assign push = (accept && neg) || rdy_done || to_done;
  assign push_entry = rdy_done ? {bus.core_sqrt, 2'b00} : to_done ? {QNAN, 2'b10} : {QNAN, 2'b01};
  assign pop = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (accept && !neg ? START : IDLE)
             : state == START ? WAIT
             : (state == WAIT && !rdy_done && !to_done) ? WAIT : IDLE;
  end
  always_comb begin
    bus.core_start = state == START;
    bus.busy = state != IDLE;
    bus.out_valid = count != '0;
    bus.out_data = bus.out_valid ? mem[rp][WIDTH+1:2] : '0;
    bus.out_flags = bus.out_valid ? mem[rp][1:0] : 2'b00;
  end
  // a slot is reserved at accept time, so push can never hit a full FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      wd <= '0;
      bus.core_a <= '0;
    end else begin
      if (accept && !neg) bus.core_a <= bus.in_data;
      wd <= state == START ? '0 : state == WAIT ? wd + 1'b1 : wd;
      if (push) begin
        mem[wp] <= push_entry;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_sqrt_f32_issue.sv
// tb_sqrt_f32_issue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_sqrt_f32_issue;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic clk, rst;
  int n_checks = 0, n_fail = 0;
  int core_lat = 10, c_cnt, start_cnt;
  bit core_stuck = 0, core_clr = 1;
  logic [33:0] exp_q[$];

  sqrt_f32_issue_if #(.WIDTH(32)) bus ();
  sqrt_f32_issue #(.WIDTH(32), .DEPTH(2), .TIMEOUT(40)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 0;
  always #5 clk = ~clk;

  // stand-in for the sqrt core: known roots for directed values, an arbitrary fixed map otherwise
  function automatic logic [31:0] core_fn(input logic [31:0] a);
    case (a)
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h3F80_0000: return 32'h3F80_0000;
      32'h8000_0000: return 32'h8000_0000;
      default:       return {~a[15:0], a[31:16]};
    endcase
  endfunction

  function automatic bit is_neg(input logic [31:0] a);
    bit zero = a[30:0] == 0;
    bit nan = a[30:23] == 8'hFF && a[22:0] != 0;
    return a[31] && !zero && !nan;
  endfunction

  function automatic logic [31:0] gen_op();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return {1'b1, 31'($urandom)};
      2: return 32'h8000_0000;
      3: return 32'hFF80_0000;
      4: return {9'h1FF, 23'($urandom_range(1, 32'h7FFFFF))};
      default: return {1'b0, 31'($urandom)};
    endcase
  endfunction

  always @(posedge clk) begin
    if (core_clr) begin
      c_cnt <= 0;
      bus.core_rdy <= 1'b0;
      bus.core_sqrt <= '0;
    end else if (bus.core_start) begin
      c_cnt <= core_lat;
      bus.core_rdy <= 1'b0;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1 && !core_stuck) begin
        bus.core_rdy <= 1'b1;
        bus.core_sqrt <= core_fn(bus.core_a);
      end
    end
  end

  always @(posedge clk)
    if (core_clr) start_cnt <= 0;
    else if (bus.core_start) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = a;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait in_ready got %b want 1 within 300 cycles", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle busy got %b want 0 within 100 cycles", bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    core_clr = 0;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start got %b want 0", bus.core_start); end
    n_checks++; if (bus.core_a !== 32'h0) begin n_fail++; $display("FAIL reset_core_a got %h want 0", bus.core_a); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if ({bus.out_data, bus.out_flags} !== 34'h0) begin n_fail++; $display("FAIL reset_out got %h/%b want 0/00", bus.out_data, bus.out_flags); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int n = 0, extra = 0, s0 = start_cnt;
    bus.out_ready = 1'b1;
    core_lat = 10;
    send(32'h4080_0000);
    while (!bus.out_valid && n < 60) begin
      tick();
      n++;
    end
    n_checks++; if (n !== core_lat + 2) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", n, core_lat + 2); end
    n_checks++; if ({bus.out_data, bus.out_flags} !== {32'h4000_0000, 2'b00}) begin n_fail++; $display("FAIL basic_result got %h/%b want 40000000/00", bus.out_data, bus.out_flags); end
    repeat (6) begin
      tick();
      if (bus.out_valid) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL basic_single_output got %0d extra want 0", extra); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", bus.busy); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL basic_starts got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_negative();
    int s0 = start_cnt;
    bus.out_ready = 1'b1;
    send(32'hC080_0000);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL neg_valid got %b want 1", bus.out_valid); end
    n_checks++; if ({bus.out_data, bus.out_flags} !== {QNAN, 2'b01}) begin n_fail++; $display("FAIL neg_result got %h/%b want 7fc00000/01", bus.out_data, bus.out_flags); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL neg_in_ready got %b want 1", bus.in_ready); end
    repeat (4) tick();
    n_checks++; if (start_cnt !== s0) begin n_fail++; $display("FAIL neg_no_start got %0d starts want 0", start_cnt - s0); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL neg_drained got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    int stuck_ready = 0;
    bus.out_ready = 1'b0;
    core_lat = 8;
    send(32'h4110_0000);
    send(32'h3F80_0000);
    wait_idle();
    repeat (5) begin
      tick();
      if (bus.in_ready) stuck_ready++;
    end
    n_checks++; if (stuck_ready !== 0) begin n_fail++; $display("FAIL bp_in_ready got %0d cycles high want 0", stuck_ready); end
    n_checks++; if (bus.core_a !== 32'h3F80_0000) begin n_fail++; $display("FAIL bp_core_a got %h want 3f800000", bus.core_a); end
    n_checks++; if ({bus.out_data, bus.out_flags} !== {32'h4040_0000, 2'b00}) begin n_fail++; $display("FAIL bp_first got %h/%b want 40400000/00", bus.out_data, bus.out_flags); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_flags} !== {1'b1, 32'h3F80_0000, 2'b00}) begin n_fail++; $display("FAIL bp_second got %b/%h/%b want 1/3f800000/00", bus.out_valid, bus.out_data, bus.out_flags); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_timeout();
    int early = 0, n = 0;
    core_stuck = 1;
    bus.out_ready = 1'b1;
    send(32'h4080_0000);
    repeat (40) begin
      tick();
      if (bus.out_valid || !bus.busy) early++;
    end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL to_early got %0d cycles want 0", early); end
    tick();
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_flags} !== {1'b1, QNAN, 2'b10}) begin n_fail++; $display("FAIL to_result got %b/%h/%b want 1/7fc00000/10", bus.out_valid, bus.out_data, bus.out_flags); end
    core_stuck = 0;
    core_lat = 5;
    tick();
    send(32'h4110_0000);
    while (!bus.out_valid && n < 60) begin
      tick();
      n++;
    end
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_flags} !== {1'b1, 32'h4040_0000, 2'b00}) begin n_fail++; $display("FAIL to_recover got %b/%h/%b want 1/40400000/00", bus.out_valid, bus.out_data, bus.out_flags); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.out_ready = 1'b1;
    core_lat = 20;
    send(32'h4080_0000);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready_low got %b want 0", bus.in_ready); end
    tick();
    n_checks++; if ({bus.busy, bus.core_start, bus.out_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_ctrl got busy/start/valid %b want 000", {bus.busy, bus.core_start, bus.out_valid}); end
    n_checks++; if ({bus.core_a, bus.out_data, bus.out_flags} !== 66'h0) begin n_fail++; $display("FAIL rmid_data got %h/%h/%b want 0", bus.core_a, bus.out_data, bus.out_flags); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
    repeat (35) begin
      tick();
      if (bus.out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_output got %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    core_lat = 5;
    send(32'h8000_0000);
    wait_idle();
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_flags} !== {1'b1, 32'h8000_0000, 2'b00}) begin n_fail++; $display("FAIL b2b_negzero got %b/%h/%b want 1/80000000/00", bus.out_valid, bus.out_data, bus.out_flags); end
    bus.in_valid = 1'b1;
    bus.in_data = 32'hC080_0000;
    bus.out_ready = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_flags} !== {1'b1, QNAN, 2'b01}) begin n_fail++; $display("FAIL b2b_head got %b/%h/%b want 1/7fc00000/01", bus.out_valid, bus.out_data, bus.out_flags); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_count got valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_random();
    localparam int N = 40;
    int n_sent = 0, n_got = 0;
    bit acc;
    logic [33:0] e;
    exp_q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = gen_op();
    for (int cyc = 0; cyc < 6000 && n_got < N; cyc++) begin
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected got %h/%b want no output", bus.out_data, bus.out_flags);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_data, bus.out_flags} !== e) begin n_fail++; $display("FAIL rand_result got %h/%b want %h/%b", bus.out_data, bus.out_flags, e[33:2], e[1:0]); end
        end
        n_got++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        exp_q.push_back(is_neg(bus.in_data) ? {QNAN, 2'b01} : {core_fn(bus.in_data), 2'b00});
        n_sent++;
      end
      tick();
      bus.out_ready = $urandom_range(0, 3) != 0;
      core_lat = $urandom_range(1, 25);
      if (acc || !bus.in_valid) begin
        bus.in_valid = n_sent < N && $urandom_range(0, 3) != 0;
        bus.in_data = gen_op();
      end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (n_got !== N || exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_drain got %0d outputs %0d pending want %0d/0", n_got, exp_q.size(), N); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
